instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage sitting directly upstream of Memory_System.
- Drives the word address into the instruction region and captures the returned instruction word.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports redirect (branch/jump target) with flush, plus text-segment range and alignment fault detection.

Parameters:
DATA_WIDTH, 32, width of address, instruction and PC
RESET_PC, 32'h0040_0000, PC loaded on reset
TEXT_BASE, 32'h0040_0000, first byte address of instruction region
TEXT_DEPTH, 64, instruction region size in words
FIFO_DEPTH, 4, instruction buffer entries (power of 2, at least 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
Address_o  out  DATA_WIDTH  fetch address to Memory_System, combinational copy of PC
Instruction_i  in  DATA_WIDTH  word read at Address_o, valid in the same cycle (combinational read)
Redirect_i  in  1  load new PC and flush buffer
Redirect_Target_i  in  DATA_WIDTH  new PC when Redirect_i=1
Instr_Valid_o  out  1  FIFO head valid
Instr_o  out  DATA_WIDTH  instruction at FIFO head
Instr_PC_o  out  DATA_WIDTH  PC of instruction at FIFO head
Instr_Ready_i  in  1  decode accepts head this cycle
Fault_o  out  1  fetch halted on bad PC
Fault_PC_o  out  DATA_WIDTH  offending PC

Behaviour:
- Reset (reset=0 at clk edge) wins over everything.
  - PC=RESET_PC, FIFO count=0, state=RUN.
  - Instr_Valid_o=0, Instr_o=0, Instr_PC_o=0, Fault_o=0, Fault_PC_o=0.
  - Reset mid-stream discards all buffered entries.
- PC in range: PC[1:0]==0 and TEXT_BASE <= PC <= TEXT_BASE+4*TEXT_DEPTH-4.
- FSM states: RUN, FAULT.
- RUN, no redirect:
  - PC out of range: go to FAULT, latch Fault_PC_o=PC, no push, PC held.
  - PC in range and FIFO not full: push {PC, Instruction_i}, PC<=PC+4.
  - FIFO full: hold PC, no push, even if a pop occurs in the same cycle.
- FAULT: no pushes, PC held, Fault_o=1. Already-buffered entries may still drain normally.
- Redirect_i=1 (any state):
  - FIFO cleared, any same-cycle pop or push is discarded, PC<=Redirect_Target_i.
  - State<=RUN, Fault_o<=0, Fault_PC_o keeps its last value.
  - Range check applies to the new PC on the following cycle.
- Pop occurs when Instr_Valid_o && Instr_Ready_i. The head advances on that edge.
- Instr_Valid_o = (count != 0).
- Instr_o and Instr_PC_o are taken from registered FIFO storage; latency from fetch to head = 1 cycle when the FIFO was empty.
- Empty FIFO with Instr_Ready_i=1: no pop, no change.
- Push and pop in the same cycle (not full, not empty): count unchanged, pointers both advance.
- Pointers wrap modulo FIFO_DEPTH.
- PC+4 arithmetic is modulo 2^DATA_WIDTH. Wrap yields an out-of-range PC and therefore a FAULT.
- Throughput with Instr_Ready_i held at 1: one instruction per cycle.

Optional Feature:
FETCH_PERF_COUNT_EN
- Defined:
  - Adds outputs Fetch_Count_o [31:0] (increments on every push) and Stall_Count_o [31:0] (increments each RUN cycle with PC in range and FIFO full).
  - Both clear on reset, saturate at 32'hFFFF_FFFF, and are unaffected by redirect.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Memory model holds 0x2008ffff, 0x20090010, 0x200a000a, 0x200b0019 at 0x00400000..0x0040000C; release reset, Instr_Ready_i=1 -> Instr_Valid_o=1 from cycle 1, Instr_o/Instr_PC_o = 0x2008ffff/0x00400000, 0x20090010/0x00400004, ... on consecutive cycles.
- Instr_Ready_i=0 for 8 cycles after reset -> exactly 4 pushes, Address_o stuck at 0x00400010, head stays 0x2008ffff/0x00400000; raising ready -> 4 buffered words drain in order, fetch resumes at 0x00400010.
- Run to end of region -> last push PC=0x004000FC; next cycle Fault_o=1, Fault_PC_o=0x00400100, Address_o held at 0x00400100.
- Redirect_i=1, target 0x00400008, with FIFO holding 3 entries and ready=1 -> next cycle Instr_Valid_o=0, Address_o=0x00400008; following cycle head = 0x200a000a/0x00400008.
- Redirect to 0x00400002 -> next cycle Fault_o=1, Fault_PC_o=0x00400002; then redirect to 0x00400000 -> Fault_o=0, fetch restarts with 0x2008ffff.
- Assert reset with FIFO full and Fault_o=1 -> next cycle Instr_Valid_o=0, Fault_o=0, Address_o=0x00400000, and with FETCH_PERF_COUNT_EN both counters read 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives PC to the instruction memory, buffers {PC, word} pairs in a small FIFO for decode.
// Optional macro FETCH_PERF_COUNT_EN adds saturating fetch/stall counters.
module instruction_fetch_unit #(
  parameter int unsigned                 DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]       RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0]       TEXT_BASE  = 32'h0040_0000,
  parameter int unsigned                 TEXT_DEPTH = 64,
  parameter int unsigned                 FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_Target_i,
  output logic                  Instr_Valid_o,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] Instr_PC_o,
  input  logic                  Instr_Ready_i,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fault_PC_o,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0]           Fetch_Count_o,
  output logic [31:0]           Stall_Count_o,
`endif
  output logic                  o_dbg_state
);

  // Decode handshake: an entry leaves the head on a clock edge where
  // Instr_Valid_o && Instr_Ready_i, unless a redirect flushes that same edge.

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] TEXT_LAST = TEXT_BASE + DATA_WIDTH'(4 * TEXT_DEPTH - 4);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_fault_pc;
  logic [DATA_WIDTH-1:0] r_buf_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_buf_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_in_range;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_fault_latch;
  logic w_stall;

  assign w_in_range = (r_pc[1:0] == 2'b00) && (r_pc >= TEXT_BASE) && (r_pc <= TEXT_LAST);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && Instr_Ready_i && !Redirect_i;
  assign w_stall    = (r_state == ST_RUN) && w_in_range && w_full;

  // The range check takes priority over the full check, so a bad PC faults even with a full buffer.
  always_comb begin
    w_state_next  = r_state;
    w_push        = 1'b0;
    w_fault_latch = 1'b0;
    if (Redirect_i) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (!w_in_range) begin
        w_state_next  = ST_FAULT;
        w_fault_latch = 1'b1;
      end else if (!w_full) begin
        w_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (Redirect_i) begin
        r_pc     <= Redirect_Target_i;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_buf_instr[r_wr_ptr] <= Instruction_i;
          r_buf_pc[r_wr_ptr]    <= r_pc;
          r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
          r_pc                  <= r_pc + DATA_WIDTH'(4);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
        if (w_fault_latch) begin
          r_fault_pc <= r_pc;
        end
      end
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  // Counters survive redirects and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_push && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign Fetch_Count_o = r_fetch_count;
  assign Stall_Count_o = r_stall_count;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
`endif

  assign Address_o     = r_pc;
  assign Instr_Valid_o = !w_empty;
  assign Instr_o       = r_buf_instr[r_rd_ptr];
  assign Instr_PC_o    = r_buf_pc[r_rd_ptr];
  assign Fault_o       = (r_state == ST_FAULT);
  assign Fault_PC_o    = r_fault_pc;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory model, expected-entry queue, scenario tasks.
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address_o;
  logic [31:0] Instruction_i;
  logic        Redirect_i = 1'b0;
  logic [31:0] Redirect_Target_i = '0;
  logic        Instr_Valid_o;
  logic [31:0] Instr_o;
  logic [31:0] Instr_PC_o;
  logic        Instr_Ready_i = 1'b0;
  logic        Fault_o;
  logic [31:0] Fault_PC_o;
  logic        o_dbg_state;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] Fetch_Count_o;
  logic [31:0] Stall_Count_o;
`endif

  logic [31:0] mem [64];
  logic [63:0] exp_q[$];
  int total = 0;
  int bad = 0;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .Address_o         (Address_o),
    .Instruction_i     (Instruction_i),
    .Redirect_i        (Redirect_i),
    .Redirect_Target_i (Redirect_Target_i),
    .Instr_Valid_o     (Instr_Valid_o),
    .Instr_o           (Instr_o),
    .Instr_PC_o        (Instr_PC_o),
    .Instr_Ready_i     (Instr_Ready_i),
    .Fault_o           (Fault_o),
    .Fault_PC_o        (Fault_PC_o),
`ifdef FETCH_PERF_COUNT_EN
    .Fetch_Count_o     (Fetch_Count_o),
    .Stall_Count_o     (Stall_Count_o),
`endif
    .o_dbg_state       (o_dbg_state)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  logic [31:0] mem_off;
  always_comb begin
    mem_off       = Address_o - BASE;
    Instruction_i = 32'h0;
    if (mem_off < 32'd256 && mem_off[1:0] == 2'b00) Instruction_i = mem[mem_off[7:2]];
  end

  task automatic push_exp(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - BASE;
    exp_q.push_back({pc, mem[off[7:2]]});
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk); #1;
    reset = 1'b0; Redirect_i = 1'b0; Instr_Ready_i = rdy;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Scoreboard: every accepted head entry must match the oldest expectation.
  task automatic monitor_loop();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && !Redirect_i && Instr_Valid_o && Instr_Ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h, required no entry", Instr_PC_o, Instr_o);
        end else begin
          e = exp_q.pop_front();
          if ({Instr_PC_o, Instr_o} !== e) begin
            bad++;
            $display("FAIL sb_entry: got pc=%h instr=%h, required pc=%h instr=%h",
                     Instr_PC_o, Instr_o, e[63:32], e[31:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0; Instr_Ready_i = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      total++; if (Instr_Valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", Instr_Valid_o); end
      total++; if (Instr_o !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h required 0", Instr_o); end
      total++; if (Instr_PC_o !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h required 0", Instr_PC_o); end
      total++; if (Fault_o !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b required 0", Fault_o); end
      total++; if (Fault_PC_o !== 32'h0) begin bad++; $display("FAIL rst_fault_pc: got %h required 0", Fault_PC_o); end
      total++; if (Address_o !== BASE) begin bad++; $display("FAIL rst_addr: got %h required %h", Address_o, BASE); end
      total++; if (o_dbg_state !== 1'b0) begin bad++; $display("FAIL rst_state: got %b required 0", o_dbg_state); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream_to_fault();
    do_reset(1'b1);
    for (int i = 0; i < 64; i++) push_exp(BASE + 32'(4 * i));
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      total++;
      if (Instr_Valid_o !== 1'b1 || Fault_o !== 1'b0) begin
        bad++; $display("FAIL stream_valid: cycle %0d got valid=%b fault=%b required 1/0", i, Instr_Valid_o, Fault_o);
      end
    end
    @(negedge clk);
    total++; if (Fault_o !== 1'b1) begin bad++; $display("FAIL end_fault: got %b required 1", Fault_o); end
    total++; if (Fault_PC_o !== 32'h0040_0100) begin bad++; $display("FAIL end_fault_pc: got %h required 00400100", Fault_PC_o); end
    total++; if (Address_o !== 32'h0040_0100) begin bad++; $display("FAIL end_addr: got %h required 00400100", Address_o); end
    total++; if (Instr_Valid_o !== 1'b0) begin bad++; $display("FAIL end_valid: got %b required 0", Instr_Valid_o); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL end_drained: got %0d left required 0", exp_q.size()); end
    @(negedge clk);
    total++; if (Address_o !== 32'h0040_0100 || Fault_o !== 1'b1) begin
      bad++; $display("FAIL fault_hold: got addr=%h fault=%b required 00400100/1", Address_o, Fault_o);
    end
  endtask

  task automatic test_stall_then_drain();
    int n;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) push_exp(BASE + 32'(4 * i));
    @(negedge clk);
    repeat (4) @(negedge clk);
    total++; if (Address_o !== 32'h0040_0010) begin bad++; $display("FAIL stall_addr4: got %h required 00400010", Address_o); end
    repeat (4) @(negedge clk);
    total++; if (Address_o !== 32'h0040_0010) begin bad++; $display("FAIL stall_addr8: got %h required 00400010", Address_o); end
    total++; if (Instr_Valid_o !== 1'b1 || Instr_o !== 32'h2008ffff || Instr_PC_o !== BASE) begin
      bad++; $display("FAIL stall_head: got v=%b %h/%h required 1 2008ffff/00400000", Instr_Valid_o, Instr_o, Instr_PC_o);
    end
    @(posedge clk); #1;
    Instr_Ready_i = 1'b1;
    @(negedge clk);
    total++; if (Address_o !== 32'h0040_0010) begin bad++; $display("FAIL drain_addr0: got %h required 00400010", Address_o); end
    @(negedge clk);
    total++; if (Address_o !== 32'h0040_0010) begin bad++; $display("FAIL full_pop_hold: got %h required 00400010", Address_o); end
    @(negedge clk);
    total++; if (Address_o !== 32'h0040_0014) begin bad++; $display("FAIL resume_addr: got %h required 00400014", Address_o); end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clk); #1; n++; end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain_timeout: got %0d left required 0", exp_q.size()); end
    @(posedge clk); #1;
    Instr_Ready_i = 1'b0;
  endtask

  task automatic test_redirect_flush();
    int n;
    do_reset(1'b0);
    @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0008; Instr_Ready_i = 1'b1;
    @(posedge clk); #1;
    Redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(32'h0040_0008 + 32'(4 * i));
    @(negedge clk);
    total++; if (Instr_Valid_o !== 1'b0) begin bad++; $display("FAIL redir_flush: got valid=%b required 0", Instr_Valid_o); end
    total++; if (Address_o !== 32'h0040_0008) begin bad++; $display("FAIL redir_addr: got %h required 00400008", Address_o); end
    @(negedge clk);
    total++; if (Instr_o !== 32'h200a000a || Instr_PC_o !== 32'h0040_0008) begin
      bad++; $display("FAIL redir_head: got %h/%h required 200a000a/00400008", Instr_o, Instr_PC_o);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clk); #1; n++; end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL redir_drain_timeout: got %0d left required 0", exp_q.size()); end
    @(posedge clk); #1;
    Instr_Ready_i = 1'b0;
  endtask

  task automatic test_misalign_fault();
    int n;
    do_reset(1'b0);
    Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_0002;
    @(posedge clk); #1;
    Redirect_i = 1'b0;
    @(negedge clk);
    total++; if (Fault_o !== 1'b0 || Address_o !== 32'h0040_0002) begin
      bad++; $display("FAIL mis_load: got fault=%b addr=%h required 0/00400002", Fault_o, Address_o);
    end
    @(negedge clk);
    total++; if (Fault_o !== 1'b1 || Fault_PC_o !== 32'h0040_0002 || o_dbg_state !== 1'b1) begin
      bad++; $display("FAIL mis_fault: got fault=%b fpc=%h st=%b required 1/00400002/1", Fault_o, Fault_PC_o, o_dbg_state);
    end
    total++; if (Instr_Valid_o !== 1'b0) begin bad++; $display("FAIL mis_nopush: got valid=%b required 0", Instr_Valid_o); end
    @(posedge clk); #1;
    Redirect_i = 1'b1; Redirect_Target_i = BASE; Instr_Ready_i = 1'b1;
    @(posedge clk); #1;
    Redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(BASE + 32'(4 * i));
    @(negedge clk);
    total++; if (Fault_o !== 1'b0 || Fault_PC_o !== 32'h0040_0002 || Address_o !== BASE) begin
      bad++; $display("FAIL mis_recover: got fault=%b fpc=%h addr=%h required 0/00400002/00400000", Fault_o, Fault_PC_o, Address_o);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clk); #1; n++; end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mis_drain_timeout: got %0d left required 0", exp_q.size()); end
    @(posedge clk); #1;
    Instr_Ready_i = 1'b0;
  endtask

  task automatic test_reset_full_fault();
    do_reset(1'b0);
    Redirect_i = 1'b1; Redirect_Target_i = 32'h0040_00F0;
    @(posedge clk); #1;
    Redirect_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (Fault_o !== 1'b1 || Instr_Valid_o !== 1'b1 || Fault_PC_o !== 32'h0040_0100 || Address_o !== 32'h0040_0100) begin
      bad++; $display("FAIL full_fault: got fault=%b v=%b fpc=%h addr=%h required 1/1/00400100/00400100",
                      Fault_o, Instr_Valid_o, Fault_PC_o, Address_o);
    end
    total++; if (Instr_PC_o !== 32'h0040_00F0) begin bad++; $display("FAIL full_head: got %h required 004000f0", Instr_PC_o); end
`ifdef FETCH_PERF_COUNT_EN
    total++; if (Fetch_Count_o !== 32'd4) begin bad++; $display("FAIL perf_fetch: got %0d required 4", Fetch_Count_o); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    total++; if (Instr_Valid_o !== 1'b0 || Fault_o !== 1'b0 || Address_o !== BASE) begin
      bad++; $display("FAIL mid_reset: got v=%b fault=%b addr=%h required 0/0/00400000", Instr_Valid_o, Fault_o, Address_o);
    end
    total++; if (Fault_PC_o !== 32'h0 || Instr_o !== 32'h0 || Instr_PC_o !== 32'h0) begin
      bad++; $display("FAIL mid_reset_regs: got fpc=%h instr=%h pc=%h required 0/0/0", Fault_PC_o, Instr_o, Instr_PC_o);
    end
`ifdef FETCH_PERF_COUNT_EN
    total++; if (Fetch_Count_o !== 32'd0 || Stall_Count_o !== 32'd0) begin
      bad++; $display("FAIL perf_reset: got %0d/%0d required 0/0", Fetch_Count_o, Stall_Count_o);
    end
`endif
  endtask

  initial begin
    mem[0] = 32'h2008ffff;
    mem[1] = 32'h20090010;
    mem[2] = 32'h200a000a;
    mem[3] = 32'h200b0019;
    for (int i = 4; i < 64; i++) mem[i] = $urandom_range(32'h7fff_ffff, 0);
    fork
      monitor_loop();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_stream_to_fault();
    test_stall_then_drain();
    test_redirect_flush();
    test_misalign_fault();
    test_reset_full_fault();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
